// File: rtl/ins_prefetch_reg.sv
// Instruction register with a DEPTH-entry prefetch queue in front of it.
// Words are fetched ahead over a valid/ready handshake and loaded into the opcode/operand register on ir_load.
module ins_prefetch_reg #(
  parameter int OPC_W = 4,
  parameter int OPR_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OPC_W+OPR_W-1:0]   instr_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     ir_load,
  input  logic                     flush,
  output logic [OPC_W-1:0]         opcode,
  output logic [OPR_W-1:0]         operand,
  output logic                     ir_valid,
  output logic [CNT_W-1:0]         count
);

  localparam int IW    = OPC_W + OPR_W;
  localparam int PTR_W = $clog2(DEPTH);

  logic [IW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [OPC_W-1:0] r_opcode;
  logic [OPR_W-1:0] r_operand;
  logic             r_ir_valid;

  logic             w_empty;
  logic             w_full;
  logic             w_load;
  logic             w_pop;
  logic             w_bypass;
  logic             w_push;
  logic [IW-1:0]    w_head;

  // Full/empty come from the registered count only, so in_ready has no combinational input path.
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_load   = ir_load && !flush;
  assign w_pop    = w_load && !w_empty;
  assign w_bypass = w_load && w_empty && in_valid;
  assign w_push   = in_valid && !w_full && !w_bypass && !flush;
  assign w_head   = r_mem[r_rd_ptr];

  assign in_ready = !w_full;
  assign opcode   = r_opcode;
  assign operand  = r_operand;
  assign ir_valid = r_ir_valid;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr] <= instr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An empty-queue load with nothing incoming retires the instruction but keeps the old fields visible.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_opcode   <= '0;
      r_operand  <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_pop) begin
      r_opcode   <= w_head[IW-1:OPR_W];
      r_operand  <= w_head[OPR_W-1:0];
      r_ir_valid <= 1'b1;
    end else if (w_bypass) begin
      r_opcode   <= instr_in[IW-1:OPR_W];
      r_operand  <= instr_in[OPR_W-1:0];
      r_ir_valid <= 1'b1;
    end else if (w_load) begin
      r_ir_valid <= 1'b0;
    end
  end

  countInRange: assert property (@(posedge clk) disable iff (rst) r_count <= CNT_W'(DEPTH));
  noPushWhenFull: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_ins_prefetch_reg.sv
// Directed bench for ins_prefetch_reg: default 4x(4+4) instance plus an 8-deep 4+8 instance.
// Inputs change 1ns after a rising edge, outputs are checked 1ns after the next one.
module tb_ins_prefetch_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       aRst, aInValid, aInReady, aIrLoad, aFlush, aIrValid;
  logic [7:0] aInstr;
  logic [3:0] aOpcode, aOperand;
  logic [2:0] aCount;

  logic        bRst, bInValid, bInReady, bIrLoad, bFlush, bIrValid;
  logic [11:0] bInstr;
  logic [3:0]  bOpcode;
  logic [7:0]  bOperand;
  logic [3:0]  bCount;

  int vectors = 0;
  int miscompares = 0;

  ins_prefetch_reg dutA (
    .clk(clk), .rst(aRst), .instr_in(aInstr), .in_valid(aInValid), .in_ready(aInReady),
    .ir_load(aIrLoad), .flush(aFlush), .opcode(aOpcode), .operand(aOperand),
    .ir_valid(aIrValid), .count(aCount)
  );

  ins_prefetch_reg #(.OPC_W(4), .OPR_W(8), .DEPTH(8)) dutB (
    .clk(clk), .rst(bRst), .instr_in(bInstr), .in_valid(bInValid), .in_ready(bInReady),
    .ir_load(bIrLoad), .flush(bFlush), .opcode(bOpcode), .operand(bOperand),
    .ir_valid(bIrValid), .count(bCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on instance sel (0 = A, 1 = B); the other instance idles.
  task automatic applyStimulus(input int sel, input logic r, input logic v,
                               input logic [11:0] instr, input logic ld, input logic fl);
    if (sel == 0) begin
      aRst = r; aInValid = v; aInstr = instr[7:0]; aIrLoad = ld; aFlush = fl;
    end else begin
      bRst = r; bInValid = v; bInstr = instr; bIrLoad = ld; bFlush = fl;
    end
    @(posedge clk);
    #1;
    aRst = 1'b0; aInValid = 1'b0; aIrLoad = 1'b0; aFlush = 1'b0;
    bRst = 1'b0; bInValid = 1'b0; bIrLoad = 1'b0; bFlush = 1'b0;
  endtask

  task automatic checkA(input string tag, input logic [3:0] opc, input logic [3:0] opr,
                        input logic vld, input logic [2:0] cnt, input logic rdy);
    checkOutput({tag, ".opcode"}, 32'(aOpcode), 32'(opc));
    checkOutput({tag, ".operand"}, 32'(aOperand), 32'(opr));
    checkOutput({tag, ".ir_valid"}, 32'(aIrValid), 32'(vld));
    checkOutput({tag, ".count"}, 32'(aCount), 32'(cnt));
    checkOutput({tag, ".in_ready"}, 32'(aInReady), 32'(rdy));
  endtask

  task automatic checkB(input string tag, input logic [3:0] opc, input logic [7:0] opr,
                        input logic vld, input logic [3:0] cnt, input logic rdy);
    checkOutput({tag, ".opcode"}, 32'(bOpcode), 32'(opc));
    checkOutput({tag, ".operand"}, 32'(bOperand), 32'(opr));
    checkOutput({tag, ".ir_valid"}, 32'(bIrValid), 32'(vld));
    checkOutput({tag, ".count"}, 32'(bCount), 32'(cnt));
    checkOutput({tag, ".in_ready"}, 32'(bInReady), 32'(rdy));
  endtask

  logic [7:0] fillA [4] = '{8'h0A, 8'h2B, 8'h3C, 8'hE0};

  initial begin
    aRst = 1'b1; aInValid = 1'b0; aInstr = '0; aIrLoad = 1'b0; aFlush = 1'b0;
    bRst = 1'b1; bInValid = 1'b0; bInstr = '0; bIrLoad = 1'b0; bFlush = 1'b0;
    @(posedge clk);
    #1;

    // ---- instance A: default parameters ----
    applyStimulus(0, 1, 0, 12'h0, 0, 0);
    checkA("reset", 4'h0, 4'h0, 0, 3'd0, 1);

    applyStimulus(0, 0, 1, 12'h01E, 1, 0);
    checkA("bypass", 4'h1, 4'hE, 1, 3'd0, 1);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, {4'h0, fillA[i]}, 0, 0);
    checkA("fill", 4'h1, 4'hE, 1, 3'd4, 0);

    applyStimulus(0, 0, 1, 12'h0F0, 0, 0);
    checkA("pushWhenFull", 4'h1, 4'hE, 1, 3'd4, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 12'h0, 1, 0);
      checkA($sformatf("drain%0d", i), fillA[i][7:4], fillA[i][3:0], 1, 3'(3 - i), 1);
    end

    applyStimulus(0, 0, 0, 12'h0, 1, 0);
    checkA("loadEmpty", 4'hE, 4'h0, 0, 3'd0, 1);

    applyStimulus(0, 0, 1, 12'h011, 0, 0);
    applyStimulus(0, 0, 1, 12'h022, 0, 0);
    applyStimulus(0, 0, 1, 12'h05D, 1, 0);
    checkA("pushPop", 4'h1, 4'h1, 1, 3'd2, 1);
    applyStimulus(0, 0, 0, 12'h0, 1, 0);
    checkA("orderOld", 4'h2, 4'h2, 1, 3'd1, 1);
    applyStimulus(0, 0, 0, 12'h0, 1, 0);
    checkA("orderNew", 4'h5, 4'hD, 1, 3'd0, 1);

    applyStimulus(0, 0, 1, 12'h001, 0, 0);
    applyStimulus(0, 0, 1, 12'h002, 0, 0);
    applyStimulus(0, 0, 1, 12'h003, 0, 0);
    checkA("preFlush", 4'h5, 4'hD, 1, 3'd3, 1);
    applyStimulus(0, 0, 1, 12'h077, 1, 1);
    checkA("flush", 4'h0, 4'h0, 0, 3'd0, 1);
    applyStimulus(0, 0, 0, 12'h0, 1, 0);
    checkA("afterFlushLoad", 4'h0, 4'h0, 0, 3'd0, 1);
    applyStimulus(0, 0, 1, 12'h044, 0, 0);
    applyStimulus(0, 0, 0, 12'h0, 1, 0);
    checkA("afterFlushFifo", 4'h4, 4'h4, 1, 3'd0, 1);

    // ---- instance B: OPC_W=4, OPR_W=8, DEPTH=8 ----
    applyStimulus(1, 1, 0, 12'h0, 0, 0);
    checkB("bReset", 4'h0, 8'h00, 0, 4'd0, 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 12'(12'h100 + i), 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 12'h0, 1, 0);
      checkB($sformatf("bPre%0d", i), 4'h1, 8'(i), 1, 4'(2 - i), 1);
    end

    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, {4'(i + 1), 8'(8'h30 + i)}, 0, 0);
    checkB("bFull", 4'h1, 8'h02, 1, 4'd8, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 12'h0, 1, 0);
      checkB($sformatf("bWrap%0d", i), 4'(i + 1), 8'(8'h30 + i), 1, 4'(7 - i), 1);
    end

    applyStimulus(1, 0, 1, 12'hABC, 0, 0);
    applyStimulus(1, 0, 1, 12'hDEF, 0, 0);
    checkB("bRefill", 4'h8, 8'h37, 1, 4'd2, 1);
    applyStimulus(1, 1, 1, 12'h123, 1, 0);
    checkB("bMidReset", 4'h0, 8'h00, 0, 4'd0, 1);
    applyStimulus(1, 0, 0, 12'h0, 1, 0);
    checkB("bEmptyAfterReset", 4'h0, 8'h00, 0, 4'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
